// File: rtl/riscv_alu_pkg.sv
// Shared ALU op encoding, datapath widths and legality check for the
// decode/execute boundary.
package riscv_alu_pkg;
  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SLL  = 4'b0001,
    SLT  = 4'b0010,
    SLTU = 4'b0011,
    XOR  = 4'b0100,
    SRL  = 4'b0101,
    OR   = 4'b0110,
    AND  = 4'b0111,
    SUB  = 4'b1000,
    SRA  = 4'b1101
  } alu_op_t;

  function automatic logic is_legal_alu_op(input logic [3:0] op);
    case (op)
      ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND, SUB, SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/fwd_select.sv
// Priority forwarding mux for one source operand: EX/MEM, then MEM/WB,
// then the supplied register value. x0 always yields zero.
module fwd_select #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic [RIDX_W-1:0] idx,
  input  logic [XLEN-1:0]   rf_data,
  input  logic [RIDX_W-1:0] exmem_rd,
  input  logic              exmem_we,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [RIDX_W-1:0] memwb_rd,
  input  logic              memwb_we,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   data
);
  always_comb begin
    data = rf_data;
    if (idx == '0)                            data = '0;
    else if (exmem_we && (exmem_rd == idx))   data = exmem_result;
    else if (memwb_we && (memwb_rd == idx))   data = memwb_result;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instructions, forwards RAW
// operands at capture and keeps refreshing them while execute stalls.
module id_ex_stage
  import riscv_alu_pkg::*;
#(
  parameter int XLEN   = riscv_alu_pkg::XLEN,
  parameter int RIDX_W = riscv_alu_pkg::RIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [RIDX_W-1:0] in_rs1,
  input  logic [RIDX_W-1:0] in_rs2,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [3:0]        in_alu_op,
  input  logic              in_use_imm,
  input  logic              in_use_pc,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic [RIDX_W-1:0] exmem_rd,
  input  logic              exmem_we,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [RIDX_W-1:0] memwb_rd,
  input  logic              memwb_we,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_d1,
  output logic [XLEN-1:0]   alu_d2,
  output logic [3:0]        alu_control,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [RIDX_W-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic [XLEN-1:0]   ex_pc,
  output logic              ex_illegal
);
  logic              valid_q, use_imm_q, use_pc_q, reg_write_q;
  logic [XLEN-1:0]   pc_q, imm_q, rs1v_q, rs2v_q;
  logic [RIDX_W-1:0] rs1_q, rs2_q, rd_q;
  logic [3:0]        op_q;

  logic              hold, capture;
  logic [RIDX_W-1:0] src1_idx, src2_idx;
  logic [XLEN-1:0]   src1_data, src2_data, fwd1, fwd2;

  assign in_ready = !valid_q || ex_ready || flush;
  assign capture  = in_valid && in_ready && !flush;
  assign hold     = valid_q && !ex_ready;

  // One mux per operand: the source switches between the incoming
  // instruction and the held one, since capture and hold never coincide.
  assign src1_idx  = hold ? rs1_q  : in_rs1;
  assign src2_idx  = hold ? rs2_q  : in_rs2;
  assign src1_data = hold ? rs1v_q : in_rs1_data;
  assign src2_data = hold ? rs2v_q : in_rs2_data;

  fwd_select #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd1 (
    .idx(src1_idx), .rf_data(src1_data),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_we(memwb_we), .memwb_result(memwb_result),
    .data(fwd1)
  );

  fwd_select #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd2 (
    .idx(src2_idx), .rf_data(src2_data),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_we(memwb_we), .memwb_result(memwb_result),
    .data(fwd2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      reg_write_q <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1v_q      <= '0;
      rs2v_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      op_q        <= ADD;
    end else begin
      if (flush)         valid_q <= 1'b0;
      else if (capture)  valid_q <= 1'b1;
      else if (ex_ready) valid_q <= 1'b0;

      if (capture) begin
        use_imm_q   <= in_use_imm;
        use_pc_q    <= in_use_pc;
        reg_write_q <= in_reg_write;
        pc_q        <= in_pc;
        imm_q       <= in_imm;
        rs1_q       <= in_rs1;
        rs2_q       <= in_rs2;
        rd_q        <= in_rd;
        op_q        <= in_alu_op;
      end
      // Held operands pick up producers that retire during the stall.
      if (capture || (hold && !flush)) begin
        rs1v_q <= fwd1;
        rs2v_q <= fwd2;
      end
    end
  end

  assign ex_valid      = valid_q;
  assign alu_d1        = use_pc_q  ? pc_q  : rs1v_q;
  assign alu_d2        = use_imm_q ? imm_q : rs2v_q;
  assign ex_store_data = rs2v_q;
  assign ex_rd         = rd_q;
  assign ex_pc         = pc_q;
  assign ex_illegal    = !is_legal_alu_op(op_q);
  assign alu_control   = is_legal_alu_op(op_q) ? op_q : ADD;
  assign ex_reg_write  = reg_write_q && valid_q && (rd_q != '0);
endmodule
